// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
//
// Purpose : shared definitions for the APB write master and its helpers:
//           default bus widths, error-counter width, access-timeout default,
//           and the transfer state encoding.
//
// Contents:
//   APB_ADDR_W, APB_DATA_W  default APB address / data widths
//   APB_ERR_CNT_W           default width of the saturating error counter
//   APB_TIMEOUT_CYCLES      default ACCESS-phase wait limit
//   apb_state_t             2-bit state type
//   IDLE / SETUP / ACCESS   state constants (plain localparams so the encoding
//                           stays visible to legacy tooling and waveforms)
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W         = 32;
    localparam int APB_DATA_W         = 32;
    localparam int APB_ERR_CNT_W      = 8;
    localparam int APB_TIMEOUT_CYCLES = 256;

    typedef logic [1:0] apb_state_t;

    // IDLE   : bus quiet, psel = 0
    // SETUP  : psel = 1, penable = 0, one cycle only
    // ACCESS : psel = 1, penable = 1, held until pready (or abort)
    localparam apb_state_t IDLE   = 2'd0;
    localparam apb_state_t SETUP  = 2'd1;
    localparam apb_state_t ACCESS = 2'd2;

endpackage : apb_pkg

// File: rtl/apb_write_master_if.sv
// ----------------------------------------------------------------------------
// apb_write_master_if
//
// Purpose : APB3 write-side bus bundle between a write master and a slave
//           (or interconnect). Only the signals a write-only master needs.
//
// Signals:
//   psel, penable, pwrite   master -> slave control
//   paddr  [ADDR_W]         master -> slave address
//   pwdata [DATA_W]         master -> slave write data
//   pready, pslverr         slave  -> master completion / error
//
// Modports:
//   master : drives the control/address/data, samples pready/pslverr
//   slave  : the mirror view
// ----------------------------------------------------------------------------
interface apb_write_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output pready,
        output pslverr
    );

endinterface : apb_write_master_if

// File: rtl/apb_hold_reg.sv
// ----------------------------------------------------------------------------
// apb_hold_reg
//
// Purpose : one-entry valid/ready hold register for an address/data word.
//           A word is captured when in_valid && in_ready. The entry is freed
//           by pop; a word offered in the same cycle as pop is captured
//           straight away, so a consumer that pops every other cycle sees no
//           bubble. The stored address/data are kept after the entry is freed
//           (only hold_valid drops), which lets the consumer keep driving the
//           last value onto a bus without a separate register.
//
// Ports:
//   apb_clk, apb_reset        clock, synchronous active-high reset
//   in_addr, in_data          incoming word
//   in_valid / in_ready       upstream handshake (in_ready is combinational)
//   pop                       consumer has finished with the held word
//   hold_valid                entry occupied
//   hold_addr, hold_data      stored word (last captured value)
// ----------------------------------------------------------------------------
module apb_hold_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              apb_clk,
    input  logic              apb_reset,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pop,
    output logic              hold_valid,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_data
);

    logic              hold_valid_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic              accept;

    // Space is available when empty, or when the current word leaves this cycle.
    assign in_ready = !hold_valid_reg || pop;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            hold_valid_reg <= 1'b0;
            hold_addr_reg  <= '0;
            hold_data_reg  <= '0;
        end else begin
            if (accept) begin
                hold_valid_reg <= 1'b1;
                hold_addr_reg  <= in_addr;
                hold_data_reg  <= in_data;
            end else if (pop) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    assign hold_valid = hold_valid_reg;
    assign hold_addr  = hold_addr_reg;
    assign hold_data  = hold_data_reg;

endmodule : apb_hold_reg

// File: rtl/apb_write_master.sv
// ----------------------------------------------------------------------------
// apb_write_master
//
// Purpose : turns the bridge's 32-bit address/data word stream (valid/ready)
//           into APB3 write transfers: SETUP, then ACCESS held until pready.
//           Slave errors (pslverr on the completing cycle) are counted in a
//           saturating counter and the failing address is recorded.
//
// Build option:
//   APB_TIMEOUT_EN  when defined, an ACCESS phase that sees no pready for
//                   TIMEOUT_CYCLES cycles is aborted, pulses timeout and is
//                   counted as an error. When undefined, ACCESS waits forever
//                   and timeout is tied low.
//
// Ports:
//   apb_clk, apb_reset        clock, synchronous active-high reset
//   in_addr, in_data          word from the bridge
//   in_valid / in_ready       word handshake (in_ready combinational)
//   apb                       APB bus, master modport
//   busy                      word held or transfer in progress
//   err_count                 saturating count of errored transfers
//   err_addr                  paddr of the most recent errored transfer
//   timeout                   one-cycle abort pulse (timeout build only)
// ----------------------------------------------------------------------------
module apb_write_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int ERR_CNT_W      = APB_ERR_CNT_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                 apb_clk,
    input  logic                 apb_reset,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    apb_write_master_if.master   apb,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr,
    output logic                 timeout
);

    apb_state_t state_reg;
    apb_state_t state_next;

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    logic done;       // ACCESS completed by the slave
    logic abort;      // ACCESS given up on (timeout build only)
    logic pop;        // current word leaves the hold register
    logic accept;     // new word captured this cycle
    logic err_event;

    logic [ERR_CNT_W-1:0] err_count_reg;
    logic [ADDR_W-1:0]    err_addr_reg;

    // ------------------------------------------------------------------------
    // Hold register. It doubles as the address/data output register: its
    // contents cannot change during SETUP/ACCESS because in_ready is low there
    // until the completing cycle, and it keeps the last word once emptied.
    // ------------------------------------------------------------------------
    apb_hold_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .apb_clk    (apb_clk),
        .apb_reset  (apb_reset),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pop        (pop),
        .hold_valid (hold_valid),
        .hold_addr  (hold_addr),
        .hold_data  (hold_data)
    );

    assign accept = in_valid && in_ready;
    assign done   = (state_reg == ACCESS) && apb.pready;
    assign pop    = done || abort;

    // ------------------------------------------------------------------------
    // Optional ACCESS-phase watchdog
    // ------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;

    // pready on the final wait cycle takes priority: that is a normal completion.
    assign abort = (state_reg == ACCESS) && !apb.pready && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= abort;
            if (state_reg == SETUP) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == ACCESS) && !apb.pready && !abort) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (hold_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // A word accepted on the completing cycle goes straight to
                // SETUP, keeping psel high for back-to-back transfers.
                if (pop) begin
                    state_next = accept ? SETUP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Error capture. pslverr only counts together with a completing pready;
    // an aborted access is counted as an error as well.
    // ------------------------------------------------------------------------
    assign err_event = (done && apb.pslverr) || abort;

    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            err_count_reg <= '0;
            err_addr_reg  <= '0;
        end else if (err_event) begin
            if (err_count_reg != {ERR_CNT_W{1'b1}}) begin
                err_count_reg <= err_count_reg + ERR_CNT_W'(1);
            end
            err_addr_reg <= hold_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Control decodes straight from the state register; address and
    // data come from the hold register and therefore keep their last value
    // while idle.
    // ------------------------------------------------------------------------
    assign apb.psel    = (state_reg != IDLE);
    assign apb.penable = (state_reg == ACCESS);
    assign apb.pwrite  = (state_reg != IDLE);
    assign apb.paddr   = hold_addr;
    assign apb.pwdata  = hold_data;

    assign busy      = hold_valid || (state_reg != IDLE);
    assign err_count = err_count_reg;
    assign err_addr  = err_addr_reg;

endmodule : apb_write_master

// File: tb/tb_apb_write_master.sv
// ----------------------------------------------------------------------------
// tb_apb_write_master
//
// Drives directed word sequences into apb_write_master against a scripted
// APB slave (configurable wait states, per-transfer error plan, pready and
// pslverr driven high as noise whenever they must be ignored). A timeline
// model of accepted words predicts the bus every cycle; directed literal
// checks pin cycle counts and error results. Timeout scenarios are built
// only when APB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_write_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int EW    = 8;
    localparam int TB_TO = 16;

    logic          apb_clk   = 1'b0;
    logic          apb_reset = 1'b1;
    logic [AW-1:0] in_addr   = '0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          busy;
    logic [EW-1:0] err_count;
    logic [AW-1:0] err_addr;
    logic          timeout;

    apb_write_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_write_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .ERR_CNT_W      (EW),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .apb_clk   (apb_clk),
        .apb_reset (apb_reset),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .apb       (bus),
        .busy      (busy),
        .err_count (err_count),
        .err_addr  (err_addr),
        .timeout   (timeout)
    );

    always #5 apb_clk = ~apb_clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Scripted slave: ws wait states per ACCESS, error flag per transfer from
    // err_plan. Outside a real completion pready/pslverr are driven as noise.
    // ------------------------------------------------------------------------
    int   ws      = 0;
    int   acc_cnt = 0;
    logic err_cur = 1'b0;
    logic err_plan[$];

    initial begin
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
    end

    always @(posedge apb_clk) begin
        #1;
        if (bus.psel && bus.penable) begin
            if (acc_cnt == 0) begin
                err_cur = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
            end
            bus.pready  = (acc_cnt >= ws);
            bus.pslverr = bus.pready ? err_cur : 1'b1;
            acc_cnt++;
        end else begin
            acc_cnt     = 0;
            bus.pready  = 1'b1;
            bus.pslverr = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Timeline model: each accepted word gets the cycle on which its SETUP
    // must appear; ACCESS follows until the slave completes it (or it times
    // out). Checked against the DUT on every falling edge.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            setup;
    } xfer_t;

    xfer_t         q[$];
    int            cyc        = 0;
    int            errors     = 0;
    logic [AW-1:0] m_err_addr = '0;
    logic          to_pending = 1'b0;
    int            psel_cnt   = 0;
    int            pen_cnt    = 0;
    int            to_cnt     = 0;
    int            nready_cnt = 0;
    int            xfer_no    = 0;

    always @(negedge apb_clk) begin
        logic  have, e_pen, e_done, e_abort, e_ready, is_err;
        xfer_t x;
        cyc++;
        have    = (q.size() > 0) && (q[0].setup <= cyc);
        e_pen   = have && (cyc > q[0].setup);
        e_done  = e_pen && bus.pready;
        e_abort = 1'b0;
`ifdef APB_TIMEOUT_EN
        e_abort = e_pen && !bus.pready && ((cyc - q[0].setup) == TB_TO);
`endif
        e_ready = (q.size() == 0) || e_done || e_abort;

        check("psel",      bus.psel,    have);
        check("penable",   bus.penable, e_pen);
        check("pwrite",    bus.pwrite,  have);
        if (have) begin
            check("paddr",  bus.paddr,  q[0].addr);
            check("pwdata", bus.pwdata, q[0].data);
        end
        check("in_ready",  in_ready,  e_ready);
        check("busy",      busy,      q.size() > 0);
        check("err_count", err_count, (errors > 255) ? 255 : errors);
        check("err_addr",  err_addr,  m_err_addr);
        check("timeout",   timeout,   to_pending);

        if (bus.psel)    psel_cnt++;
        if (bus.penable) pen_cnt++;
        if (timeout)     to_cnt++;
        if (!in_ready)   nready_cnt++;

        if (apb_reset) begin
            q.delete();
            errors     = 0;
            m_err_addr = '0;
            to_pending = 1'b0;
        end else begin
            to_pending = e_abort;
            if (e_done || e_abort) begin
                x      = q.pop_front();
                is_err = e_abort || bus.pslverr;
                if (is_err) begin
                    errors++;
                    m_err_addr = x.addr;
                end
                xfer_no++;
                $display("xfer %0d addr=0x%08h data=0x%08h err=%0b abort=%0b",
                         xfer_no, x.addr, x.data, is_err, e_abort);
            end
            if (in_valid && e_ready) begin
                x.addr  = in_addr;
                x.data  = in_data;
                x.setup = (e_done || e_abort) ? cyc + 1 : cyc + 2;
                q.push_back(x);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called and returning at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        while (!acc && n < 2000) begin
            @(negedge apb_clk);
            acc = in_ready;
            @(posedge apb_clk);
            #1;
            n++;
        end
        check("send_accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge apb_clk);
            n++;
        end while ((busy || bus.psel) && n < 5000);
        check("idle_reached", (n < 5000), 1'b1);
        @(posedge apb_clk);
        #1;
    endtask

    task automatic clear_counts();
        psel_cnt   = 0;
        pen_cnt    = 0;
        to_cnt     = 0;
        nready_cnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---------------- reset state ----------------
        apb_reset = 1'b1;
        repeat (3) @(posedge apb_clk);
        #1 apb_reset = 1'b0;
        @(negedge apb_clk);
        check("rst_psel",      bus.psel,    1'b0);
        check("rst_penable",   bus.penable, 1'b0);
        check("rst_paddr",     bus.paddr,   32'h0);
        check("rst_pwdata",    bus.pwdata,  32'h0);
        check("rst_err_count", err_count,   8'h00);
        check("rst_in_ready",  in_ready,    1'b1);
        check("rst_busy",      busy,        1'b0);
        @(posedge apb_clk);
        #1;

        // ---------------- reset in the middle of ACCESS ----------------
        ws = 1000;
        send_word(32'h4000_0000, 32'h1111_1111);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge apb_clk);
            n++;
        end while (!bus.penable && n < 100);
        check("mid_access_reached", bus.penable, 1'b1);
        repeat (2) @(negedge apb_clk);
        @(posedge apb_clk);
        #1 apb_reset = 1'b1;
        @(posedge apb_clk);
        @(posedge apb_clk);
        #1 apb_reset = 1'b0;
        ws = 0;
        @(negedge apb_clk);
        check("midrst_psel",      bus.psel,    1'b0);
        check("midrst_penable",   bus.penable, 1'b0);
        check("midrst_err_count", err_count,   8'h00);
        check("midrst_in_ready",  in_ready,    1'b1);
        check("midrst_busy",      busy,        1'b0);
        @(posedge apb_clk);
        #1;

        // ---------------- single word, no wait states ----------------
        send_word(32'h4000_0010, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        @(negedge apb_clk);
        check("single_c1_psel", bus.psel, 1'b0);
        check("single_c1_busy", busy,     1'b1);
        @(negedge apb_clk);
        check("single_setup_psel",    bus.psel,    1'b1);
        check("single_setup_penable", bus.penable, 1'b0);
        check("single_setup_paddr",   bus.paddr,   32'h4000_0010);
        check("single_setup_pwdata",  bus.pwdata,  32'hDEAD_BEEF);
        @(negedge apb_clk);
        check("single_access_penable", bus.penable, 1'b1);
        check("single_access_paddr",   bus.paddr,   32'h4000_0010);
        check("single_access_pwdata",  bus.pwdata,  32'hDEAD_BEEF);
        @(negedge apb_clk);
        check("single_idle_psel",  bus.psel,  1'b0);
        check("single_idle_paddr", bus.paddr, 32'h4000_0010);
        @(posedge apb_clk);
        #1;

        // ---------------- three wait states ----------------
        ws = 3;
        clear_counts();
        send_word(32'h4000_0020, 32'h0BAD_F00D);
        in_valid = 1'b0;
        wait_idle();
        check("ws_penable_cycles", pen_cnt,    4);
        check("ws_psel_cycles",    psel_cnt,   5);
        check("ws_notready_cycles", nready_cnt, 5);
        ws = 0;

        // ---------------- four words back to back ----------------
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            send_word(32'h4000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        wait_idle();
        check("b2b_psel_cycles",    psel_cnt, 8);
        check("b2b_penable_cycles", pen_cnt,  4);

        // ---------------- slave error on word 2 of 3 ----------------
        err_plan.push_back(1'b0);
        err_plan.push_back(1'b1);
        err_plan.push_back(1'b0);
        send_word(32'h0000_000C, 32'h0000_0001);
        send_word(32'h0000_0010, 32'h0000_0002);
        send_word(32'h0000_0014, 32'h0000_0003);
        in_valid = 1'b0;
        wait_idle();
        check("err_count_one", err_count, 8'h01);
        check("err_addr_0x10", err_addr,  32'h0000_0010);

`ifdef APB_TIMEOUT_EN
        // ---------------- access timeout, then a normal word ----------------
        ws = 1000;
        clear_counts();
        send_word(32'h4000_0200, 32'h7777_7777);
        in_valid = 1'b0;
        wait_idle();
        ws = 0;
        check("to_penable_cycles", pen_cnt,   TB_TO);
        check("to_pulses",         to_cnt,    1);
        check("to_err_count",      err_count, 8'h02);
        check("to_err_addr",       err_addr,  32'h4000_0200);
        clear_counts();
        send_word(32'h4000_0204, 32'h8888_8888);
        in_valid = 1'b0;
        wait_idle();
        check("after_to_psel_cycles", psel_cnt,  2);
        check("after_to_pulses",      to_cnt,    0);
        check("after_to_err_count",   err_count, 8'h02);
`endif

        // ---------------- error counter saturation ----------------
        for (int i = 0; i < 300; i++) err_plan.push_back(1'b1);
        for (int i = 0; i < 300; i++) begin
            send_word(32'h5000_0000 + 32'(4 * i), 32'(i));
        end
        in_valid = 1'b0;
        wait_idle();
        check("sat_err_count", err_count, 8'hFF);
        check("sat_err_addr",  err_addr,  32'h5000_04AC);

        repeat (2) @(posedge apb_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_write_master
